// File: rtl/arb_idx_fifo.sv
// Circular FIFO of arbiter winner indices, kept in request order.
// Push/pop are ignored when full/empty; flush clears all bookkeeping synchronously.
module arb_idx_fifo #(
   parameter int unsigned Depth    = 8,
   parameter int unsigned Width    = 2,
   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic                push_i,
   input  logic [Width-1:0]    data_i,
   input  logic                pop_i,
   output logic [Width-1:0]    data_o,
   output logic                full_o,
   output logic                empty_o,
   output logic [CntWidth-1:0] count_o
);

   logic [Width-1:0]    r_mem [Depth];
   logic [PtrWidth-1:0] r_wr_ptr;
   logic [PtrWidth-1:0] r_rd_ptr;
   logic [CntWidth-1:0] r_count;
   logic                w_push;
   logic                w_pop;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PtrWidth-1:0] f_next(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
   endfunction

   assign full_o  = (r_count == CntWidth'(Depth));
   assign empty_o = (r_count == '0);
   assign count_o = r_count;
   assign data_o  = r_mem[r_rd_ptr];
   assign w_push  = push_i & ~full_o & ~flush_i;
   assign w_pop   = pop_i & ~empty_o & ~flush_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < Depth; i++) begin
            r_mem[i] <= '0;
         end
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
            r_wr_ptr        <= f_next(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_next(r_rd_ptr);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CntWidth'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CntWidth'(1);
         end
      end
   end

endmodule

// File: rtl/arb_resp_router.sv
// Routes in-order single-beat responses back to the arbiter input that issued
// the oldest outstanding request, and bounds the number of outstanding requests.
module arb_resp_router #(
   parameter int unsigned NumIn     = 4,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned MaxTxns   = 8,
   localparam int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1,
   localparam int unsigned CntWidth = $clog2(MaxTxns + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 arb_req_i,
   input  logic [IdxWidth-1:0]  arb_idx_i,
   output logic                 arb_gnt_o,
   output logic                 slv_req_o,
   input  logic                 slv_gnt_i,
   input  logic                 rsp_valid_i,
   output logic                 rsp_ready_o,
   input  logic [DataWidth-1:0] rsp_data_i,
   output logic [NumIn-1:0]     rsp_valid_o,
   input  logic [NumIn-1:0]     rsp_ready_i,
   output logic [DataWidth-1:0] rsp_data_o,
   output logic [CntWidth-1:0]  outstanding_o,
   output logic                 full_o,
   output logic                 empty_o
);

   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic                w_rsp_en;
   logic [IdxWidth-1:0] w_head;
   logic [NumIn-1:0]    w_head_oh;

   arb_idx_fifo #(
      .Depth (MaxTxns),
      .Width (IdxWidth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (w_push),
      .data_i  (arb_idx_i),
      .pop_i   (w_pop),
      .data_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (outstanding_o)
   );

   // Grant depends only on occupancy, never on the response side.
   assign arb_gnt_o = slv_gnt_i & ~w_full & ~flush_i;
   assign slv_req_o = arb_req_i & ~w_full & ~flush_i;
   assign w_push    = arb_req_i & arb_gnt_o;
   assign w_rsp_en  = ~w_empty & ~flush_i;
   assign w_pop     = rsp_valid_i & rsp_ready_o;

   always_comb begin
      w_head_oh = '0;
      for (int i = 0; i < NumIn; i++) begin
         w_head_oh[i] = (w_head == IdxWidth'(i));
      end
   end

   assign rsp_valid_o = (rsp_valid_i & w_rsp_en) ? w_head_oh : '0;
   assign rsp_ready_o = (|(rsp_ready_i & w_head_oh)) & w_rsp_en;
   assign rsp_data_o  = rsp_data_i;
   assign full_o      = w_full;
   assign empty_o     = w_empty;

`ifndef SYNTHESIS
   a_no_stray_rsp : assert property (@(posedge clk_i) disable iff (rst_i)
      !(rsp_valid_i && w_empty));
   a_onehot_valid : assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0(rsp_valid_o));
   a_cnt_bound : assert property (@(posedge clk_i) disable iff (rst_i)
      32'(outstanding_o) <= MaxTxns);
   a_idx_range : assert property (@(posedge clk_i) disable iff (rst_i)
      w_push |-> (32'(arb_idx_i) < NumIn));
`endif

endmodule

// File: tb/tb_arb_resp_router.sv
// Directed and randomized checks of arb_resp_router against a queue-based model
// of outstanding request indices.
module tb_arb_resp_router;

   localparam int NumIn     = 4;
   localparam int DataWidth = 32;
   localparam int MaxTxns   = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        arb_req = 1'b0;
   logic [1:0]  arb_idx = '0;
   logic        slv_gnt = 1'b0;
   logic        rsp_valid = 1'b0;
   logic [31:0] rsp_data = '0;
   logic [3:0]  rsp_ready = '0;
   logic        arb_gnt;
   logic        slv_req;
   logic        rsp_rdy_o;
   logic [3:0]  rsp_vld_o;
   logic [31:0] rsp_data_o;
   logic [3:0]  outstanding;
   logic        full;
   logic        empty;

   int n_cmp = 0;
   int n_err = 0;
   int q[$];

   arb_resp_router #(
      .NumIn     (NumIn),
      .DataWidth (DataWidth),
      .MaxTxns   (MaxTxns)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .flush_i       (flush),
      .arb_req_i     (arb_req),
      .arb_idx_i     (arb_idx),
      .arb_gnt_o     (arb_gnt),
      .slv_req_o     (slv_req),
      .slv_gnt_i     (slv_gnt),
      .rsp_valid_i   (rsp_valid),
      .rsp_ready_o   (rsp_rdy_o),
      .rsp_data_i    (rsp_data),
      .rsp_valid_o   (rsp_vld_o),
      .rsp_ready_i   (rsp_ready),
      .rsp_data_o    (rsp_data_o),
      .outstanding_o (outstanding),
      .full_o        (full),
      .empty_o       (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive after the falling edge, check combinational outputs, then
   // apply the model's push/pop/flush at the rising edge.
   task automatic step(input logic req, input logic [1:0] idx, input logic sg, input logic rv,
                       input logic [3:0] rr, input logic fl, input logic [31:0] data);
      bit       is_full, is_empty, exp_push, exp_pop, exp_rr;
      int       head;
      logic [3:0] exp_rv;
      @(negedge clk);
      arb_req = req; arb_idx = idx; slv_gnt = sg; rsp_valid = rv;
      rsp_ready = rr; flush = fl; rsp_data = data;
      #1;
      is_full  = (q.size() == MaxTxns);
      is_empty = (q.size() == 0);
      head     = is_empty ? 0 : q[0];
      exp_rv   = (rv && !is_empty && !fl) ? 4'(1 << head) : 4'b0;
      exp_rr   = !is_empty && !fl && rr[head];
      chk("outstanding", 32'(outstanding), q.size());
      chk("full", 32'(full), 32'(is_full));
      chk("empty", 32'(empty), 32'(is_empty));
      chk("arb_gnt", 32'(arb_gnt), 32'(sg && !is_full && !fl));
      chk("slv_req", 32'(slv_req), 32'(req && !is_full && !fl));
      chk("rsp_valid_o", 32'(rsp_vld_o), 32'(exp_rv));
      chk("rsp_ready_o", 32'(rsp_rdy_o), 32'(exp_rr));
      chk("rsp_data_o", rsp_data_o, data);
      exp_push = req && sg && !is_full && !fl;
      exp_pop  = rv && exp_rr;
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else begin
         if (exp_pop) void'(q.pop_front());
         if (exp_push) q.push_back(int'(idx));
      end
   endtask

   task automatic idle();
      step(1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0, $urandom);
   endtask

   task automatic push(input logic [1:0] idx);
      step(1'b1, idx, 1'b1, 1'b0, 4'h0, 1'b0, $urandom);
   endtask

   task automatic pop_all_ready();
      step(1'b0, 2'd0, 1'b0, 1'b1, 4'hF, 1'b0, $urandom);
   endtask

   initial begin
      // Reset state while rst is held.
      #2;
      chk("rst_outstanding", 32'(outstanding), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_rsp_valid_o", 32'(rsp_vld_o), 0);
      @(negedge clk);
      rst = 1'b0;

      // Single transaction.
      push(2'd2);
      step(1'b0, 2'd0, 1'b0, 1'b1, 4'b0100, 1'b0, 32'hA5A5_0001);
      idle();

      // In-order routing.
      push(2'd3);
      push(2'd0);
      push(2'd1);
      repeat (3) pop_all_ready();
      idle();

      // Fill, blocked push at full, pop+request at full, then push succeeds.
      for (int i = 0; i < MaxTxns; i++) push(2'($urandom_range(0, 3)));
      step(1'b1, 2'd1, 1'b1, 1'b0, 4'h0, 1'b0, $urandom);
      step(1'b1, 2'd2, 1'b1, 1'b1, 4'hF, 1'b0, $urandom);
      push(2'd1);
      // Drain to 3, then simultaneous push/pop across the pointer wrap.
      repeat (5) pop_all_ready();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b1, 4'hF, 1'b0, $urandom);
      end
      repeat (3) pop_all_ready();
      idle();

      // Back-pressure on head idx 1.
      push(2'd1);
      push(2'd2);
      repeat (5) step(1'b0, 2'd0, 1'b0, 1'b1, 4'b1101, 1'b0, $urandom);
      step(1'b0, 2'd0, 1'b0, 1'b1, 4'b0010, 1'b0, $urandom);
      pop_all_ready();
      idle();

      // Flush with 4 outstanding; everything gated during the flush cycle.
      for (int i = 0; i < 4; i++) push(2'($urandom_range(0, 3)));
      step(1'b1, 2'd3, 1'b1, 1'b1, 4'hF, 1'b1, $urandom);
      idle();

      // Asynchronous reset mid-burst.
      for (int i = 0; i < 3; i++) push(2'($urandom_range(0, 3)));
      @(negedge clk);
      arb_req = 1'b1; arb_idx = 2'd1; slv_gnt = 1'b1; rsp_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_outstanding", 32'(outstanding), 0);
      chk("async_rst_empty", 32'(empty), 1);
      @(negedge clk);
      rst = 1'b0; arb_req = 1'b0; slv_gnt = 1'b0;
      q.delete();
      idle();

      // Randomized traffic; responses only while requests are outstanding.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              (q.size() != 0) && ($urandom_range(0, 2) != 0), 4'($urandom),
              ($urandom_range(0, 47) == 0), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
